bcd2bin_seq: RTL

Sequential 3-digit packed-BCD to binary converter. It is the inverse of the combinational binary-to-BCD block and is used where front-panel or display-side BCD values (0–999) are turned back into binary for the synth datapath. It implements reverse double-dabble, one bit per clock, with a START/BUSY/DONE handshake. Invalid BCD digits are flagged with ERR.

---
 rtl/bcd2bin_seq.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/bcd2bin_seq.sv
// bcd2bin_seq: sequential packed-BCD to binary converter.
// Reverse double-dabble, one bit per clock. A request accepted in IDLE
// loads the operand into the upper (BCD) part of a shift register. Each
// CONV step shifts the whole register right by one and corrects every BCD
// digit that has reached 8 or more. After BIN_W steps the lower part of the
// register holds the binary value. Operands with a digit above 9 run the
// full BIN_W steps, then report ERR with a zero result.
module bcd2bin_seq #(
    parameter int DIGITS = 3,
    parameter int BIN_W  = 10,
    parameter int CNT_W  = 4
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  START,
    input  logic [4*DIGITS-1:0]   BCD,
    output logic [BIN_W-1:0]      BIN,
    output logic                  BUSY,
    output logic                  DONE,
    output logic                  ERR
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int SR_W  = BCD_W + BIN_W;

    // Value of the step counter on the last step, and a counter increment.
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIN_W - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_CONV = 1'b1
    } state_t;

    // Correct one BCD digit after a right shift: a digit of 8 or more
    // received a carried-in half-ten, so take 3 off. This is 4-bit
    // arithmetic with no carry into the next digit.
    function automatic logic [3:0] digit_fix(input logic [3:0] d);
        logic [3:0] r;
        if (d >= 4'd8) begin
            r = d - 4'd3;
        end else begin
            r = d;
        end
        return r;
    endfunction

    // Flag an operand in which any nibble is not a decimal digit.
    function automatic logic bcd_invalid(input logic [BCD_W-1:0] b);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (b[4*i +: 4] > 4'd9) begin
                bad = 1'b1;
            end else begin
                bad = bad;
            end
        end
        return bad;
    endfunction

    // One conversion step. Shift the whole register right by one with 0
    // into the MSB. Then fix every BCD digit field. The binary part is
    // never corrected.
    function automatic logic [SR_W-1:0] sr_step(input logic [SR_W-1:0] sr);
        logic [SR_W-1:0] t;
        t = sr >> 1;
        for (int i = 0; i < DIGITS; i++) begin
            t[BIN_W + 4*i +: 4] = digit_fix(t[BIN_W + 4*i +: 4]);
        end
        return t;
    endfunction

    // Architectural state
    state_t              state_q, state_d;
    logic [SR_W-1:0]     sr_q, sr_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                err_flag_q, err_flag_d;   // operand validity latched at accept
    logic [BIN_W-1:0]    bin_q, bin_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                err_q, err_d;             // ERR output, held between completions

    // Combinational helpers
    logic [SR_W-1:0]     step_s;
    logic                last_step_s;

    assign step_s      = sr_step(sr_q);
    assign last_step_s = (cnt_q == LAST_CNT);

    // State and datapath registers. Reset is synchronous and returns everything to idle.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= S_IDLE;
            sr_q       <= {SR_W{1'b0}};
            cnt_q      <= {CNT_W{1'b0}};
            err_flag_q <= 1'b0;
            bin_q      <= {BIN_W{1'b0}};
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            sr_q       <= sr_d;
            cnt_q      <= cnt_d;
            err_flag_q <= err_flag_d;
            bin_q      <= bin_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    // Next-state logic. Leave IDLE on START and return once the last step is done.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (START) begin
                    state_d = S_CONV;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_CONV: begin
                if (last_step_s) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_CONV;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Datapath next values: load on accept, step in CONV, and publish the result on the final step.
    always_comb begin
        sr_d       = sr_q;
        cnt_d      = cnt_q;
        err_flag_d = err_flag_q;
        bin_d      = bin_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        err_d      = err_q;
        case (state_q)
            S_IDLE: begin
                if (START) begin
                    sr_d       = {BCD, {BIN_W{1'b0}}};
                    cnt_d      = {CNT_W{1'b0}};
                    err_flag_d = bcd_invalid(BCD);
                    busy_d     = 1'b1;
                end else begin
                    busy_d     = 1'b0;
                end
            end
            S_CONV: begin
                sr_d  = step_s;
                cnt_d = cnt_q + CNT_ONE;
                if (last_step_s) begin
                    if (err_flag_q) begin
                        bin_d = {BIN_W{1'b0}};
                    end else begin
                        bin_d = step_s[BIN_W-1:0];
                    end
                    err_d  = err_flag_q;
                    done_d = 1'b1;
                    busy_d = 1'b0;
                end else begin
                    busy_d = 1'b1;
                end
            end
            default: begin
                sr_d       = {SR_W{1'b0}};
                cnt_d      = {CNT_W{1'b0}};
                err_flag_d = 1'b0;
                busy_d     = 1'b0;
            end
        endcase
    end

    // Output drive. Every output comes straight from a register.
    always_comb begin
        BIN  = bin_q;
        BUSY = busy_q;
        DONE = done_q;
        ERR  = err_q;
    end

endmodule
